// File: rtl/mem_write_scheduler.sv
// ============================================================================
// Module   : mem_write_scheduler
// Brief    : Round-robin arbiter mapping NB_REQ write requesters onto
//            NB_WRAGENT registered BRAM write ports, with same-cycle address
//            conflict avoidance and a saturating conflict-stall counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_write_scheduler #(
    parameter int NB_REQ     = 4,
    parameter int NB_WRAGENT = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int REQ_IDX_W  = (NB_REQ == 1) ? 1 : $clog2(NB_REQ)
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NB_REQ-1:0]                req_valid,
    output logic [NB_REQ-1:0]                req_ready,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NB_REQ*DATA_WIDTH-1:0]     req_data,
    output logic [NB_WRAGENT-1:0]            wren,
    output logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
    output logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata,
    output logic [CNT_WIDTH-1:0]             conflict_cnt
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    logic [REQ_IDX_W-1:0]            r_rr_ptr;
    logic [NB_WRAGENT-1:0]           r_wren;
    logic [NB_WRAGENT*ADDR_WIDTH-1:0] r_wraddr;
    logic [NB_WRAGENT*DATA_WIDTH-1:0] r_wrdata;
    logic [CNT_WIDTH-1:0]            r_conflict_cnt;

    logic [ADDR_WIDTH-1:0] w_req_addr [NB_REQ];
    logic [DATA_WIDTH-1:0] w_req_data [NB_REQ];
    logic [NB_REQ-1:0]     w_ready;
    logic [NB_WRAGENT-1:0] w_port_en;
    logic [ADDR_WIDTH-1:0] w_port_addr [NB_WRAGENT];
    logic [DATA_WIDTH-1:0] w_port_data [NB_WRAGENT];
    logic                  w_conflict;
    logic [REQ_IDX_W-1:0]  w_next_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < NB_REQ; gi++) begin : g_unpack
            assign w_req_addr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_req_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Scan NB_REQ positions from the pointer; each grant fills the next free port.
    always_comb begin : scan
        int                    idx;
        int                    cnt;
        int                    last;
        logic                  vld;
        logic                  hit;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;

        w_ready    = '0;
        w_port_en  = '0;
        w_conflict = 1'b0;
        w_next_ptr = r_rr_ptr;
        for (int k = 0; k < NB_WRAGENT; k++) begin
            w_port_addr[k] = '0;
            w_port_data[k] = '0;
        end
        idx  = 0;
        cnt  = 0;
        last = 0;
        vld  = 1'b0;
        hit  = 1'b0;
        addr = '0;
        data = '0;

        for (int p = 0; p < NB_REQ; p++) begin
            idx = int'(r_rr_ptr) + p;
            if (idx >= NB_REQ) idx = idx - NB_REQ;
            vld  = 1'b0;
            addr = '0;
            data = '0;
            for (int i = 0; i < NB_REQ; i++) begin
                if (i == idx) begin
                    vld  = req_valid[i];
                    addr = w_req_addr[i];
                    data = w_req_data[i];
                end
            end
            hit = 1'b0;
            for (int k = 0; k < NB_WRAGENT; k++) begin
                if (k < cnt && w_port_addr[k] == addr) hit = 1'b1;
            end
            // Address match only counts as a conflict while a port is still free.
            if (vld && cnt < NB_WRAGENT) begin
                if (hit) begin
                    w_conflict = 1'b1;
                end else begin
                    for (int k = 0; k < NB_WRAGENT; k++) begin
                        if (k == cnt) begin
                            w_port_en[k]   = 1'b1;
                            w_port_addr[k] = addr;
                            w_port_data[k] = data;
                        end
                    end
                    for (int i = 0; i < NB_REQ; i++) begin
                        if (i == idx) w_ready[i] = 1'b1;
                    end
                    cnt  = cnt + 1;
                    last = idx;
                end
            end
        end

        if (cnt > 0) begin
            w_next_ptr = (last == NB_REQ - 1) ? '0 : REQ_IDX_W'(last + 1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rr_ptr       <= '0;
            r_wren         <= '0;
            r_wraddr       <= '0;
            r_wrdata       <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_rr_ptr <= w_next_ptr;
            r_wren   <= w_port_en;
            // Idle ports keep their last address/data.
            for (int k = 0; k < NB_WRAGENT; k++) begin
                if (w_port_en[k]) begin
                    r_wraddr[k*ADDR_WIDTH +: ADDR_WIDTH] <= w_port_addr[k];
                    r_wrdata[k*DATA_WIDTH +: DATA_WIDTH] <= w_port_data[k];
                end
            end
            if (w_conflict && r_conflict_cnt != c_cnt_max) begin
                r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign req_ready    = w_ready;
    assign wren         = r_wren;
    assign wraddr       = r_wraddr;
    assign wrdata       = r_wrdata;
    assign conflict_cnt = r_conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_write_scheduler.sv
// ============================================================================
// Module   : tb_mem_write_scheduler
// Brief    : Scoreboard bench for mem_write_scheduler: directed scenarios plus
//            randomized requesters checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_write_scheduler;

    localparam int NB_REQ = 4;
    localparam int NB_WRAGENT = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic                     aclk = 1'b0;
    logic                     aresetn = 1'b0;
    logic [NB_REQ-1:0]        req_valid = '0;
    logic [NB_REQ-1:0]        req_ready;
    logic [NB_REQ*AW-1:0]     req_addr = '0;
    logic [NB_REQ*DW-1:0]     req_data = '0;
    logic [NB_WRAGENT-1:0]    wren;
    logic [NB_WRAGENT*AW-1:0] wraddr;
    logic [NB_WRAGENT*DW-1:0] wrdata;
    logic [CW-1:0]            conflict_cnt;

    mem_write_scheduler #(
        .NB_REQ(NB_REQ), .NB_WRAGENT(NB_WRAGENT), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .CNT_WIDTH(CW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .wren(wren), .wraddr(wraddr),
        .wrdata(wrdata), .conflict_cnt(conflict_cnt)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-requester pending transactions {addr, data}
    logic [AW+DW-1:0] rq [NB_REQ][$];

    // Driver: a requester holds its head transaction until a handshake retires it.
    initial begin
        logic [NB_REQ-1:0] rdy_s, vld_s;
        forever begin
            @(negedge aclk);
            #1 rdy_s = req_ready;
            vld_s = req_valid;
            @(posedge aclk);
            #1;
            for (int i = 0; i < NB_REQ; i++) begin
                if (vld_s[i] && rdy_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                req_valid[i] = (rq[i].size() > 0);
                if (rq[i].size() > 0) {req_addr[i*AW +: AW], req_data[i*DW +: DW]} = rq[i][0];
            end
        end
    end

    typedef struct {
        logic [NB_WRAGENT-1:0]    en;
        logic [NB_WRAGENT*AW-1:0] addr;
        logic [NB_WRAGENT*DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   m_ptr;
    int   m_cnt;
    logic [NB_WRAGENT*AW-1:0] m_addr;
    logic [NB_WRAGENT*DW-1:0] m_data;

    // Monitor + reference model: check last cycle's writes, then predict this cycle.
    always @(negedge aclk) begin
        exp_t e;
        logic [AW-1:0] granted[$];
        logic [NB_REQ-1:0] rdy;
        logic conf, match, dup;
        logic [AW-1:0] a;
        int last, i;
        if (!aresetn) begin
            m_ptr = 0; m_cnt = 0; m_addr = '0; m_data = '0;
            exp_q.delete();
            e.en = '0; e.addr = '0; e.data = '0;
            exp_q.push_back(e);
        end else begin
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wren", wren, e.en);
                chk("wraddr", wraddr, e.addr);
                chk("wrdata", wrdata, e.data);
            end
            chk("conflict_cnt", conflict_cnt, m_cnt);
            dup = 1'b0;
            for (int p = 0; p < NB_WRAGENT; p++)
                for (int q = p + 1; q < NB_WRAGENT; q++)
                    if (wren[p] && wren[q] && wraddr[p*AW +: AW] == wraddr[q*AW +: AW]) dup = 1'b1;
            chk("addr_unique", dup, 0);

            granted.delete();
            rdy = '0; conf = 1'b0; last = -1;
            e.en = '0; e.addr = m_addr; e.data = m_data;
            for (int p = 0; p < NB_REQ; p++) begin
                i = (m_ptr + p) % NB_REQ;
                if (req_valid[i]) begin
                    a = req_addr[i*AW +: AW];
                    match = 1'b0;
                    foreach (granted[g]) if (granted[g] == a) match = 1'b1;
                    if (granted.size() < NB_WRAGENT) begin
                        if (match) conf = 1'b1;
                        else begin
                            e.en[granted.size()] = 1'b1;
                            e.addr[granted.size()*AW +: AW] = a;
                            e.data[granted.size()*DW +: DW] = req_data[i*DW +: DW];
                            granted.push_back(a);
                            rdy[i] = 1'b1;
                            last = i;
                        end
                    end
                end
            end
            chk("req_ready", req_ready, rdy);
            if (last >= 0) m_ptr = (last + 1) % NB_REQ;
            if (conf && m_cnt < CMAX) m_cnt++;
            m_addr = e.addr; m_data = e.data;
            exp_q.push_back(e);
        end
    end

    task automatic clear_reqs();
        for (int i = 0; i < NB_REQ; i++) rq[i].delete();
        req_valid = '0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        #2 aresetn = 1'b0;
        clear_reqs();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        #2 aresetn = 1'b1;
    endtask

    task automatic push(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rq[i].push_back({a, d});
    endtask

    task automatic push_four(input logic [AW-1:0] base);
        for (int i = 0; i < NB_REQ; i++) push(i, base + AW'(i), 32'hA000_0000 + DW'(base) + DW'(i));
    endtask

    task automatic step();
        @(negedge aclk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        logic done;
        int total;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            step();
            total = 0;
            for (int i = 0; i < NB_REQ; i++) total += rq[i].size();
            if (total == 0 && req_valid == '0 && wren == '0) done = 1'b1;
        end
        chk(nm, done, 1);
    endtask

    initial begin
        logic [1:0] prev, cur;
        logic seen;

        repeat (3) @(posedge aclk);
        step();
        chk("rst_wren", wren, 0);
        chk("rst_wraddr", wraddr, 0);
        chk("rst_wrdata", wrdata, 0);
        chk("rst_cnt", conflict_cnt, 0);
        chk("rst_ready", req_ready, 0);
        #1 aresetn = 1'b1;

        // All four valid, distinct addresses
        for (int i = 0; i < NB_REQ; i++) push(i, AW'(i + 1), 32'h1000 + DW'(i));
        @(posedge aclk); step();
        chk("t1_ready0", req_ready, 4'b0011);
        step();
        chk("t1_wren0", wren, 2'b11);
        chk("t1_addr0", wraddr, 16'h0201);
        chk("t1_ready1", req_ready, 4'b1100);
        step();
        chk("t1_wren1", wren, 2'b11);
        chk("t1_addr1", wraddr, 16'h0403);

        // Reset asserted while both ports are writing
        push_four(8'h50);
        @(posedge aclk);
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            step();
            if (wren == 2'b11) seen = 1'b1;
        end
        chk("mid_wren11_seen", seen, 1);
        #1 aresetn = 1'b0;
        clear_reqs();
        #1;
        chk("mid_rst_wren", wren, 0);
        chk("mid_rst_cnt", conflict_cnt, 0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        #2 aresetn = 1'b1;
        push_four(8'h60);
        @(posedge aclk); step();
        chk("post_rst_ready", req_ready, 4'b0011);
        wait_idle("drain_post_rst");

        // Address conflict between req0 and req1
        do_reset();
        push(0, 8'h10, 32'hAAAA_0000);
        push(1, 8'h10, 32'hBBBB_1111);
        push(2, 8'h20, 32'hCCCC_2222);
        @(posedge aclk); step();
        chk("cf_ready0", req_ready, 4'b0101);
        step();
        chk("cf_wren", wren, 2'b11);
        chk("cf_addr", wraddr, 16'h2010);
        chk("cf_data0", wrdata[31:0], 32'hAAAA_0000);
        chk("cf_cnt", conflict_cnt, 1);
        chk("cf_ready1", req_ready, 4'b0010);
        step();
        chk("cf_wren1", wren, 2'b01);
        chk("cf_addr1", wraddr[7:0], 8'h10);
        chk("cf_data1", wrdata[31:0], 32'hBBBB_1111);

        // Single requester, then confirm the pointer wrapped to 0
        push(3, 8'hAA, 32'hDEAD_BEEF);
        @(posedge aclk); step();
        chk("single_ready", req_ready, 4'b1000);
        step();
        chk("single_wren", wren, 2'b01);
        chk("single_addr", wraddr[7:0], 8'hAA);
        chk("single_data", wrdata[31:0], 32'hDEAD_BEEF);
        push_four(8'h41);
        @(posedge aclk); step();
        chk("single_ptr0", req_ready, 4'b0011);
        wait_idle("drain_single");

        // Sustained conflicts: counter saturation and alternating grants
        do_reset();
        for (int n = 0; n < 12; n++) begin
            push(0, 8'h33, DW'(n));
            push(1, 8'h33, DW'(32'h100 + n));
        end
        @(posedge aclk);
        prev = 2'b00;
        for (int c = 0; c < 20; c++) begin
            step();
            cur = req_ready[1:0];
            if (c > 0) chk("sat_alternate", (cur == 2'b01 || cur == 2'b10) && cur != prev, 1);
            prev = cur;
        end
        step();
        chk("sat_cnt", conflict_cnt, CMAX);
        wait_idle("drain_sat");

        // Randomized traffic over a small address space
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            step();
            for (int i = 0; i < NB_REQ; i++)
                if (rq[i].size() == 0 && $urandom_range(0, 3) != 0)
                    push(i, AW'($urandom_range(0, 7)), $urandom);
        end
        wait_idle("drain_random");

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
